// File: rtl/mem_ctrl_dual.sv
`default_nettype none
// ============================================================================
//  Module   : mem_ctrl_dual
//  Purpose  : Memory/IO controller. It joins the CPU fetch and data ports to
//             two asynchronous SRAM banks and a memory-mapped UART. Fetch and
//             data run as two cooperating FSMs. Bank-1 data accesses overlap
//             with fetch. Bank-0 and UART data accesses serialise fetch and
//             return a NOP bubble to the fetch stage.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl_dual #(
   parameter int             DW        = 16,
   parameter int             CAW       = 16,
   parameter int             AW        = 18,
   parameter logic [CAW-1:0] BANK0_TOP = 16'h8000,
   parameter logic [CAW-1:0] UART_DATA = 16'hBF00,
   parameter logic [CAW-1:0] UART_STAT = 16'hBF01,
   parameter int             WAIT      = 1,
   parameter logic [DW-1:0]  NOP       = 16'h0800
) (
   input  logic           clk,
   input  logic           rst,
   // instruction fetch port
   input  logic [CAW-1:0] if_addr,
   output logic [DW-1:0]  if_data,
   output logic           if_valid,
   // data port
   input  logic           d_rd,
   input  logic           d_wr,
   input  logic [CAW-1:0] d_addr,
   input  logic [DW-1:0]  d_wdata,
   output logic [DW-1:0]  d_rdata,
   output logic           d_done,
   output logic           stall,
   output logic           mem_conflict,
   // SRAM bank 0 (bus shared with the UART)
   inout  wire  [DW-1:0]  ram0_data,
   output logic [AW-1:0]  ram0_addr,
   output logic           ram0_ce_n,
   output logic           ram0_oe_n,
   output logic           ram0_we_n,
   // SRAM bank 1
   inout  wire  [DW-1:0]  ram1_data,
   output logic [AW-1:0]  ram1_addr,
   output logic           ram1_ce_n,
   output logic           ram1_oe_n,
   output logic           ram1_we_n,
   // UART
   output logic           uart_rdn,
   output logic           uart_wrn,
   input  logic           data_ready,
   input  logic           tbre,
   input  logic           tsre
);

   localparam int            CW     = (WAIT < 2) ? 1 : $clog2(WAIT + 1);
   localparam logic [CW-1:0] WAIT_C = CW'(WAIT);

   typedef enum logic [2:0] {
      IDLE, ACC, WREL, U_RD, U_WR, U_TBRE, U_TSRE, DONE
   } d_state_t;

   typedef enum logic {
      F_IDLE, F_ACC
   } f_state_t;

   d_state_t         d_state;
   f_state_t         f_state;

   // data-side registers
   logic [CW-1:0]    d_cnt;
   logic             d_wr_r;
   logic             d_b1;
   logic [AW-1:0]    a_r;
   logic [DW-1:0]    wdata_r;
   logic             d0_ce_n, d0_oe_n, d0_we_n, d0_drv;
   logic             d1_drv;

   // fetch-side registers
   logic [CW-1:0]    f_cnt;
   logic [AW-1:0]    f_addr;
   logic             f_ce_n, f_oe_n;
   logic             f_valid;
   logic [DW-1:0]    f_data;

   // decode
   logic             req, is_udata, is_stat, is_b0, is_conf;
   logic             can_accept, accept_conf, bubble;

   // Address decode and acceptance; a conflicting access waits for fetch to go idle
   always_comb begin
      req         = d_rd | d_wr;
      is_udata    = (d_addr == UART_DATA);
      is_stat     = (d_addr == UART_STAT);
      is_b0       = (d_addr < BANK0_TOP);
      is_conf     = is_b0 | is_udata | is_stat;
      can_accept  = (d_state == IDLE) && req && ((f_state == F_IDLE) || !is_conf);
      accept_conf = can_accept && is_conf;
      bubble      = d_done & mem_conflict;
   end

   // Data FSM: SRAM bank 0/1 access, UART read/write/status, completion pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         d_state      <= IDLE;
         d_cnt        <= '0;
         d_wr_r       <= 1'b0;
         d_b1         <= 1'b0;
         a_r          <= '0;
         wdata_r      <= '0;
         d0_ce_n      <= 1'b1;
         d0_oe_n      <= 1'b1;
         d0_we_n      <= 1'b1;
         d0_drv       <= 1'b0;
         ram1_ce_n    <= 1'b1;
         ram1_oe_n    <= 1'b1;
         ram1_we_n    <= 1'b1;
         d1_drv       <= 1'b0;
         uart_rdn     <= 1'b1;
         uart_wrn     <= 1'b1;
         d_rdata      <= '0;
         d_done       <= 1'b0;
         mem_conflict <= 1'b0;
      end else begin
         case (d_state)
            IDLE: begin
               if (can_accept) begin
                  a_r          <= AW'(d_addr);
                  wdata_r      <= is_udata ? {{(DW-8){1'b0}}, d_wdata[7:0]} : d_wdata;
                  d_wr_r       <= d_wr;
                  d_b1         <= !is_conf;
                  mem_conflict <= is_conf;
                  d_cnt        <= '0;
                  if (is_stat) begin
                     // status register answers at once; writes to it are ignored
                     if (!d_wr)
                        d_rdata <= DW'({data_ready, tbre & tsre});
                     d_done  <= 1'b1;
                     d_state <= DONE;
                  end else if (is_udata) begin
                     if (d_wr) begin
                        d0_drv   <= 1'b1;
                        uart_wrn <= 1'b0;
                        d_state  <= U_WR;
                     end else begin
                        d_state  <= U_RD;
                     end
                  end else if (is_conf) begin
                     d0_ce_n <= 1'b0;
                     d0_oe_n <= d_wr;
                     d0_we_n <= !d_wr;
                     d0_drv  <= d_wr;
                     d_state <= ACC;
                  end else begin
                     ram1_ce_n <= 1'b0;
                     ram1_oe_n <= d_wr;
                     ram1_we_n <= !d_wr;
                     d1_drv    <= d_wr;
                     d_state   <= ACC;
                  end
               end
            end
            ACC: begin
               if (d_cnt == WAIT_C) begin
                  if (d_wr_r) begin
                     // end the write pulse but keep chip select and data one more cycle
                     d0_we_n   <= 1'b1;
                     ram1_we_n <= 1'b1;
                     d_state   <= WREL;
                  end else begin
                     d_rdata   <= d_b1 ? ram1_data : ram0_data;
                     d0_ce_n   <= 1'b1;
                     d0_oe_n   <= 1'b1;
                     ram1_ce_n <= 1'b1;
                     ram1_oe_n <= 1'b1;
                     d_done    <= 1'b1;
                     d_state   <= DONE;
                  end
               end else begin
                  d_cnt <= d_cnt + 1'b1;
               end
            end
            WREL: begin
               d0_ce_n   <= 1'b1;
               ram1_ce_n <= 1'b1;
               d0_drv    <= 1'b0;
               d1_drv    <= 1'b0;
               d_done    <= 1'b1;
               d_state   <= DONE;
            end
            U_RD: begin
               // rdn high: waiting for a byte; rdn low: two-cycle read strobe
               if (uart_rdn) begin
                  if (data_ready) begin
                     uart_rdn <= 1'b0;
                     d_cnt    <= '0;
                  end
               end else if (d_cnt != '0) begin
                  d_rdata  <= {{(DW-8){1'b0}}, ram0_data[7:0]};
                  uart_rdn <= 1'b1;
                  d_done   <= 1'b1;
                  d_state  <= DONE;
               end else begin
                  d_cnt <= d_cnt + 1'b1;
               end
            end
            U_WR: begin
               if (d_cnt != '0) begin
                  uart_wrn <= 1'b1;
                  d_state  <= U_TBRE;
               end else begin
                  d_cnt <= d_cnt + 1'b1;
               end
            end
            U_TBRE: begin
               if (tbre)
                  d_state <= U_TSRE;
            end
            U_TSRE: begin
               if (tsre) begin
                  d0_drv  <= 1'b0;
                  d_done  <= 1'b1;
                  d_state <= DONE;
               end
            end
            DONE: begin
               d_done       <= 1'b0;
               mem_conflict <= 1'b0;
               d_state      <= IDLE;
            end
            default: d_state <= IDLE;
         endcase
      end
   end

   // Fetch FSM: read bank 0 for WAIT+1 cycles, pulse valid, restart unless blocked
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         f_state <= F_IDLE;
         f_cnt   <= '0;
         f_addr  <= '0;
         f_ce_n  <= 1'b1;
         f_oe_n  <= 1'b1;
         f_valid <= 1'b0;
         f_data  <= NOP;
      end else begin
         f_valid <= 1'b0;
         case (f_state)
            F_IDLE: begin
               if (bubble)
                  f_data <= NOP;
               if (!mem_conflict && !accept_conf) begin
                  f_addr  <= AW'(if_addr);
                  f_ce_n  <= 1'b0;
                  f_oe_n  <= 1'b0;
                  f_cnt   <= '0;
                  f_state <= F_ACC;
               end
            end
            F_ACC: begin
               if (f_cnt == WAIT_C) begin
                  f_data  <= ram0_data;
                  f_valid <= 1'b1;
                  f_ce_n  <= 1'b1;
                  f_oe_n  <= 1'b1;
                  f_state <= F_IDLE;
               end else begin
                  f_cnt <= f_cnt + 1'b1;
               end
            end
            default: f_state <= F_IDLE;
         endcase
      end
   end

   // Bank 0 is owned by exactly one FSM at a time, so its strobes merge by AND
   assign ram0_addr = mem_conflict ? a_r : f_addr;
   assign ram0_ce_n = f_ce_n & d0_ce_n;
   assign ram0_oe_n = f_oe_n & d0_oe_n;
   assign ram0_we_n = d0_we_n;
   assign ram1_addr = a_r;

   assign ram0_data = d0_drv ? wdata_r : {DW{1'bz}};
   assign ram1_data = d1_drv ? wdata_r : {DW{1'bz}};

   // A conflicting access finishing hands the fetch stage a NOP bubble
   assign if_valid = f_valid | bubble;
   assign if_data  = bubble ? NOP : f_data;

   assign stall = (d_rd | d_wr) & ~d_done;

endmodule
`default_nettype wire
